// File: rtl/swap48_pkg.sv
// rtl/swap48_pkg.sv - shared widths and the 48-bit bit-order reversal helper
package swap48_pkg;

    localparam int DATA_W  = 48;
    localparam int ID_W    = 1;
    localparam int NUM_REQ = 2;

    function automatic logic [DATA_W-1:0] reverse48(input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] flipped;
        for (int i = 0; i < DATA_W; i++) begin
            flipped[i] = word[DATA_W-1-i];
        end
        return flipped;
    endfunction

endpackage

// File: rtl/swap48_arbiter_endianSwap48.sv
// rtl/swap48_arbiter_endianSwap48.sv - combinational 48-bit bit-order reversal
module endianSwap48
    import swap48_pkg::*;
(
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut
);

    assign dataOut = reverse48(dataIn);

endmodule

// File: rtl/swap48_arbiter.sv
// rtl/swap48_arbiter.sv - round-robin shared bit-reversal stage with registered output
module swap48_arbiter
    import swap48_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RESET_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [DATA_W-1:0]    req_data0,
    input  logic [DATA_W-1:0]    req_data1,
    input  logic [NUM_REQ-1:0]   req_swap,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [ID_W-1:0]      out_id,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1
);

    localparam logic RESET_PRIO_BIT = 1'(RESET_PRIO);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               prio;
    logic               loadEn;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] xfer;
    logic [DATA_W-1:0]  muxData;
    logic [DATA_W-1:0]  swappedData;
    logic               muxSwap;
    logic [ID_W-1:0]    grantId;

    assign loadEn = !out_valid || out_ready;

    // Grants are suppressed during reset so no word slips in while state is cleared.
    always_comb begin
        grant = '0;
        if (!rst && loadEn) begin
            if (req_valid[0] && req_valid[1]) begin
                grant[prio] = 1'b1;
            end else if (req_valid[0]) begin
                grant[0] = 1'b1;
            end else if (req_valid[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign xfer      = req_valid & grant;
    assign grantId   = grant[1];
    assign muxData   = grant[1] ? req_data1   : req_data0;
    assign muxSwap   = grant[1] ? req_swap[1] : req_swap[0];

    endianSwap48 uSwap (
        .dataIn  (muxData),
        .dataOut (swappedData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            prio      <= RESET_PRIO_BIT;
        end else if (loadEn) begin
            if (|xfer) begin
                out_valid <= 1'b1;
                out_data  <= muxSwap ? swappedData : muxData;
                out_id    <= grantId;
                prio      <= ~grantId;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Counters saturate so a long-running debug read never sees a wrapped value.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (xfer[0] && cnt0 != CNT_MAX) cnt0 <= cnt0 + 1'b1;
            if (xfer[1] && cnt1 != CNT_MAX) cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule
